// File: rtl/ocx_tlx_fbist_oc_responder_if.sv
// Command and response channels between the FBIST AXI-to-OpenCAPI bridge and its far-end responder.
interface ocx_tlx_fbist_oc_responder_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ID_WIDTH   = 12
);
    // Write command channel (ready/taken handshake)
    logic                  oc_write_command_ready;
    logic [ID_WIDTH-1:0]   oc_write_command_ready_id;
    logic [ADDR_WIDTH-1:0] oc_write_command_ready_address;
    logic [7:0]            oc_write_command_ready_length;
    logic [2:0]            oc_write_command_ready_size;
    logic [DATA_WIDTH-1:0] oc_write_command_ready_data;
    logic [DATA_WIDTH-1:0] oc_write_command_ready_data2;
    logic                  oc_write_command_taken;

    // Read command channel (ready/taken handshake)
    logic                  oc_read_command_ready;
    logic [ID_WIDTH-1:0]   oc_read_command_ready_id;
    logic [ADDR_WIDTH-1:0] oc_read_command_ready_address;
    logic [7:0]            oc_read_command_ready_length;
    logic [2:0]            oc_read_command_ready_size;
    logic                  oc_read_command_taken;

    // Write response channel
    logic [ID_WIDTH-1:0]   oc_trans_bid;
    logic [1:0]            oc_trans_bresp;
    logic                  oc_trans_bvalid;

    // Read data channel
    logic [ID_WIDTH-1:0]   oc_trans_rid;
    logic [DATA_WIDTH-1:0] oc_trans_rdata;
    logic [1:0]            oc_trans_rresp;
    logic [2:0]            oc_trans_ruser;
    logic                  oc_trans_rvalid;

    // Bridge side: issues commands, consumes responses
    modport master (
        output oc_write_command_ready, oc_write_command_ready_id, oc_write_command_ready_address,
               oc_write_command_ready_length, oc_write_command_ready_size,
               oc_write_command_ready_data, oc_write_command_ready_data2,
        input  oc_write_command_taken,
        output oc_read_command_ready, oc_read_command_ready_id, oc_read_command_ready_address,
               oc_read_command_ready_length, oc_read_command_ready_size,
        input  oc_read_command_taken,
        input  oc_trans_bid, oc_trans_bresp, oc_trans_bvalid,
        input  oc_trans_rid, oc_trans_rdata, oc_trans_rresp, oc_trans_ruser, oc_trans_rvalid
    );

    // Responder side: accepts commands, produces responses
    modport slave (
        input  oc_write_command_ready, oc_write_command_ready_id, oc_write_command_ready_address,
               oc_write_command_ready_length, oc_write_command_ready_size,
               oc_write_command_ready_data, oc_write_command_ready_data2,
        output oc_write_command_taken,
        input  oc_read_command_ready, oc_read_command_ready_id, oc_read_command_ready_address,
               oc_read_command_ready_length, oc_read_command_ready_size,
        output oc_read_command_taken,
        output oc_trans_bid, oc_trans_bresp, oc_trans_bvalid,
        output oc_trans_rid, oc_trans_rdata, oc_trans_rresp, oc_trans_ruser, oc_trans_rvalid
    );
endinterface

// File: rtl/ocx_tlx_fbist_oc_responder.sv
// Far-end OpenCAPI responder: round-robin command accept, 64B-granule memory,
// fixed-latency write responses and read data through independent shift pipelines.
module ocx_tlx_fbist_oc_responder #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned ID_WIDTH     = 12,
    parameter int unsigned MEM_AW       = 6,
    parameter int unsigned RESP_LATENCY = 2
) (
    input  logic                       s0_axi_aclk,
    input  logic                       s0_axi_aresetn,
    ocx_tlx_fbist_oc_responder_if.slave bus
);
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam int unsigned LAT       = RESP_LATENCY;
    localparam int unsigned B_W       = 1 + ID_WIDTH + 2;
    localparam int unsigned R_W       = 1 + ID_WIDTH + DATA_WIDTH + 2 + 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {IDLE, READ_BEAT1} state_e;

    state_e                state_q, state_d;
    logic                  prio_wr_q, prio_wr_d;
    logic [MEM_AW-1:0]     rd_idx_q, rd_idx_d;
    logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [B_W-1:0] b_pipe_q [LAT];
    logic [B_W-1:0] b_pipe_d [LAT];
    logic [R_W-1:0] r_pipe_q [LAT];
    logic [R_W-1:0] r_pipe_d [LAT];

    logic [1:0]            wr_err_c, rd_err_c;
    logic [MEM_AW-1:0]     wr_idx_c, wr_idx_p1_c, rd_idx_c;
    logic                  wr_take_c, rd_take_c, mem_we0_c, mem_we1_c;
    logic                  b_issue_c, r_issue_c;
    logic [ID_WIDTH-1:0]   b_id_c, r_id_c;
    logic [1:0]            b_resp_c, r_resp_c;
    logic [DATA_WIDTH-1:0] r_data_c;
    logic [2:0]            r_user_c;

    // Error classification with SLVERR taking precedence over DECERR
    function automatic logic [1:0] cmd_err(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [7:0] len, input logic [2:0] size);
        if (size != 3'd6 || len > 8'd1) return RESP_SLVERR;
        if ((addr >> (6 + MEM_AW)) != '0) return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    assign wr_err_c    = cmd_err(bus.oc_write_command_ready_address, bus.oc_write_command_ready_length,
                                 bus.oc_write_command_ready_size);
    assign rd_err_c    = cmd_err(bus.oc_read_command_ready_address, bus.oc_read_command_ready_length,
                                 bus.oc_read_command_ready_size);
    assign wr_idx_c    = MEM_AW'(bus.oc_write_command_ready_address >> 6);
    assign wr_idx_p1_c = MEM_AW'(wr_idx_c + 1'b1);
    assign rd_idx_c    = MEM_AW'(bus.oc_read_command_ready_address >> 6);

    // Arbitration, accept, error handling and read-beat sequencing
    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        rd_idx_d  = rd_idx_q;
        rd_id_d   = rd_id_q;
        wr_take_c = 1'b0;
        rd_take_c = 1'b0;
        mem_we0_c = 1'b0;
        mem_we1_c = 1'b0;
        b_issue_c = 1'b0;
        b_id_c    = '0;
        b_resp_c  = '0;
        r_issue_c = 1'b0;
        r_id_c    = '0;
        r_data_c  = '0;
        r_resp_c  = '0;
        r_user_c  = '0;
        case (state_q)
            IDLE: begin
                if (s0_axi_aresetn && bus.oc_write_command_ready &&
                    (prio_wr_q || !bus.oc_read_command_ready)) begin
                    wr_take_c = 1'b1;
                    prio_wr_d = 1'b0;
                    b_issue_c = 1'b1;
                    b_id_c    = bus.oc_write_command_ready_id;
                    b_resp_c  = wr_err_c;
                    mem_we0_c = (wr_err_c == RESP_OKAY);
                    mem_we1_c = (wr_err_c == RESP_OKAY) && (bus.oc_write_command_ready_length == 8'd1);
                end else if (s0_axi_aresetn && bus.oc_read_command_ready) begin
                    rd_take_c = 1'b1;
                    prio_wr_d = 1'b1;
                    r_issue_c = 1'b1;
                    r_id_c    = bus.oc_read_command_ready_id;
                    r_resp_c  = rd_err_c;
                    r_user_c  = 3'b001;
                    if (rd_err_c == RESP_OKAY) begin
                        r_data_c = mem_q[rd_idx_c];
                        if (bus.oc_read_command_ready_length == 8'd1) begin
                            r_user_c = 3'b000;
                            state_d  = READ_BEAT1;
                            rd_idx_d = MEM_AW'(rd_idx_c + 1'b1);
                            rd_id_d  = bus.oc_read_command_ready_id;
                        end
                    end
                end
            end
            READ_BEAT1: begin
                r_issue_c = 1'b1;
                r_id_c    = rd_id_q;
                r_data_c  = mem_q[rd_idx_q];
                r_resp_c  = RESP_OKAY;
                r_user_c  = 3'b001;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pipeline shift: stage 0 takes the issue, the last stage is the output register
    always_comb begin
        b_pipe_d[0] = {b_issue_c, b_id_c, b_resp_c};
        r_pipe_d[0] = {r_issue_c, r_id_c, r_data_c, r_resp_c, r_user_c};
        for (int i = 1; i < int'(LAT); i++) begin
            b_pipe_d[i] = b_pipe_q[i-1];
            r_pipe_d[i] = r_pipe_q[i-1];
        end
    end

    // Control state and response pipelines
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            state_q   <= IDLE;
            prio_wr_q <= 1'b1;
            rd_idx_q  <= '0;
            rd_id_q   <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                b_pipe_q[i] <= '0;
                r_pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            rd_idx_q  <= rd_idx_d;
            rd_id_q   <= rd_id_d;
            b_pipe_q  <= b_pipe_d;
            r_pipe_q  <= r_pipe_d;
        end
    end

    // Granule memory; contents survive reset
    always_ff @(posedge s0_axi_aclk) begin
        if (mem_we0_c) mem_q[wr_idx_c]    <= bus.oc_write_command_ready_data;
        if (mem_we1_c) mem_q[wr_idx_p1_c] <= bus.oc_write_command_ready_data2;
    end

    assign bus.oc_write_command_taken = wr_take_c;
    assign bus.oc_read_command_taken  = rd_take_c;
    assign {bus.oc_trans_bvalid, bus.oc_trans_bid, bus.oc_trans_bresp} = b_pipe_q[LAT-1];
    assign {bus.oc_trans_rvalid, bus.oc_trans_rid, bus.oc_trans_rdata,
            bus.oc_trans_rresp, bus.oc_trans_ruser} = r_pipe_q[LAT-1];
endmodule

// File: tb/tb_ocx_tlx_fbist_oc_responder.sv
// Randomized scoreboard bench for the OpenCAPI responder.
`timescale 1ns/1ps
module tb_ocx_tlx_fbist_oc_responder;
    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 512;
    localparam int unsigned IW  = 12;
    localparam int unsigned MAW = 6;
    localparam int unsigned LAT = 2;
    localparam int unsigned MEM_BYTES = 64 << MAW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ocx_tlx_fbist_oc_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    ocx_tlx_fbist_oc_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_AW(MAW), .RESP_LATENCY(LAT)
    ) dut (
        .s0_axi_aclk   (clk),
        .s0_axi_aresetn(rst_n),
        .bus           (bus)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } cmd_t;
    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
        int unsigned   due;
    } bexp_t;
    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic [2:0]    user;
        int unsigned   due;
    } rexp_t;

    cmd_t  wq[$];
    cmd_t  rq[$];
    bexp_t bq[$];
    rexp_t rsq[$];
    logic [DW-1:0] ref_mem [int];
    bit prefer_w = 1'b1;
    bit blocked  = 1'b0;

    function automatic logic [1:0] ref_err(cmd_t c);
        if (c.size != 3'd6 || c.len > 8'd1) return 2'b10;
        if (c.addr >= 64'(MEM_BYTES)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int ref_idx(logic [AW-1:0] a, int beat);
        return int'(((a / 64) + 64'(beat)) % 64'(1 << MAW));
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic cmd_t mk_cmd(logic [IW-1:0] id, logic [AW-1:0] addr, logic [7:0] len,
                                    logic [2:0] size, logic [DW-1:0] d0, logic [DW-1:0] d1);
        cmd_t c;
        c.id = id; c.addr = addr; c.len = len; c.size = size; c.d0 = d0; c.d1 = d1;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd(int unsigned err_pct);
        cmd_t c;
        c = mk_cmd(IW'($urandom), AW'($urandom_range(MEM_BYTES - 1)), 8'($urandom_range(1)),
                   3'd6, rnd_data(), rnd_data());
        if ($urandom_range(99) < err_pct) begin
            case ($urandom_range(2))
                0:       c.size = 3'($urandom_range(5));
                1:       c.len  = 8'($urandom_range(255, 2));
                default: c.addr = {32'($urandom), 32'($urandom)} | 64'(MEM_BYTES);
            endcase
        end
        return c;
    endfunction

    // Reference model: decides which command the responder must take this cycle and
    // schedules the responses it owes.
    always @(negedge clk) begin : model
        bit   exp_w;
        bit   exp_r;
        cmd_t c;
        logic [1:0] e;
        exp_w = 1'b0;
        exp_r = 1'b0;
        if (!rst_n) begin
            prefer_w = 1'b1;
            blocked  = 1'b0;
        end else if (blocked) begin
            blocked = 1'b0;
        end else if (bus.oc_write_command_ready && (prefer_w || !bus.oc_read_command_ready)) begin
            exp_w = 1'b1;
        end else if (bus.oc_read_command_ready) begin
            exp_r = 1'b1;
        end
        checks++;
        if (bus.oc_write_command_taken !== exp_w || bus.oc_read_command_taken !== exp_r) begin
            failures++;
            $display("FAIL taken cyc=%0d: got w=%b r=%b, expected w=%b r=%b", cyc,
                     bus.oc_write_command_taken, bus.oc_read_command_taken, exp_w, exp_r);
        end
        if (exp_w) begin
            c = wq.pop_front();
            e = ref_err(c);
            bq.push_back('{c.id, e, cyc + LAT});
            if (e == 2'b00) begin
                ref_mem[ref_idx(c.addr, 0)] = c.d0;
                if (c.len == 8'd1) ref_mem[ref_idx(c.addr, 1)] = c.d1;
            end
            prefer_w = 1'b0;
        end
        if (exp_r) begin
            c = rq.pop_front();
            e = ref_err(c);
            if (e != 2'b00) begin
                rsq.push_back('{c.id, '0, e, 3'b001, cyc + LAT});
            end else if (c.len == 8'd1) begin
                rsq.push_back('{c.id, ref_mem[ref_idx(c.addr, 0)], 2'b00, 3'b000, cyc + LAT});
                rsq.push_back('{c.id, ref_mem[ref_idx(c.addr, 1)], 2'b00, 3'b001, cyc + LAT + 1});
                blocked = 1'b1;
            end else begin
                rsq.push_back('{c.id, ref_mem[ref_idx(c.addr, 0)], 2'b00, 3'b001, cyc + LAT});
            end
            prefer_w = 1'b1;
        end
    end

    // Response monitor: every valid beat is matched against the oldest expectation
    always @(negedge clk) begin : monitor
        bexp_t be;
        rexp_t re;
        if (!rst_n) begin
            bq.delete();
            rsq.delete();
            checks++;
            if (bus.oc_trans_bvalid !== 1'b0 || bus.oc_trans_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL valid_in_reset cyc=%0d: bvalid=%b rvalid=%b, required 0 0", cyc,
                         bus.oc_trans_bvalid, bus.oc_trans_rvalid);
            end
        end else begin
            if (bus.oc_trans_bvalid === 1'b1) begin
                checks++;
                if (bq.size() == 0) begin
                    failures++;
                    $display("FAIL b_unexpected cyc=%0d: bvalid with bid=%h, none expected", cyc, bus.oc_trans_bid);
                end else begin
                    be = bq.pop_front();
                    if (bus.oc_trans_bid !== be.id || bus.oc_trans_bresp !== be.resp || cyc != be.due) begin
                        failures++;
                        $display("FAIL b_resp cyc=%0d: got bid=%h bresp=%b, expected bid=%h bresp=%b at cyc=%0d",
                                 cyc, bus.oc_trans_bid, bus.oc_trans_bresp, be.id, be.resp, be.due);
                    end
                end
            end else if (bq.size() > 0 && bq[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL b_missing cyc=%0d: no bvalid, expected bid=%h due cyc=%0d", cyc, bq[0].id, bq[0].due);
                void'(bq.pop_front());
            end
            if (bus.oc_trans_rvalid === 1'b1) begin
                checks++;
                if (rsq.size() == 0) begin
                    failures++;
                    $display("FAIL r_unexpected cyc=%0d: rvalid with rid=%h, none expected", cyc, bus.oc_trans_rid);
                end else begin
                    re = rsq.pop_front();
                    if (bus.oc_trans_rid !== re.id || bus.oc_trans_rdata !== re.data ||
                        bus.oc_trans_rresp !== re.resp || bus.oc_trans_ruser !== re.user || cyc != re.due) begin
                        failures++;
                        $display("FAIL r_beat cyc=%0d: got rid=%h rresp=%b ruser=%b rdata=%h, expected rid=%h rresp=%b ruser=%b rdata=%h at cyc=%0d",
                                 cyc, bus.oc_trans_rid, bus.oc_trans_rresp, bus.oc_trans_ruser, bus.oc_trans_rdata,
                                 re.id, re.resp, re.user, re.data, re.due);
                    end
                end
            end else if (rsq.size() > 0 && rsq[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL r_missing cyc=%0d: no rvalid, expected rid=%h due cyc=%0d", cyc, rsq[0].id, rsq[0].due);
                void'(rsq.pop_front());
            end
        end
    end

    task automatic idle();
        bus.oc_write_command_ready = 1'b0;
        bus.oc_read_command_ready  = 1'b0;
    endtask

    // Present queue heads, each with probability p percent
    task automatic drive(int unsigned p);
        bus.oc_write_command_ready = (wq.size() > 0) && ($urandom_range(99) < p);
        bus.oc_read_command_ready  = (rq.size() > 0) && ($urandom_range(99) < p);
        if (wq.size() > 0) begin
            bus.oc_write_command_ready_id      = wq[0].id;
            bus.oc_write_command_ready_address = wq[0].addr;
            bus.oc_write_command_ready_length  = wq[0].len;
            bus.oc_write_command_ready_size    = wq[0].size;
            bus.oc_write_command_ready_data    = wq[0].d0;
            bus.oc_write_command_ready_data2   = wq[0].d1;
        end
        if (rq.size() > 0) begin
            bus.oc_read_command_ready_id      = rq[0].id;
            bus.oc_read_command_ready_address = rq[0].addr;
            bus.oc_read_command_ready_length  = rq[0].len;
            bus.oc_read_command_ready_size    = rq[0].size;
        end
    endtask

    // Feed queued commands until consumed, then let responses drain
    task automatic run(int unsigned p, int unsigned max_cyc);
        int unsigned n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wq.size() == 0 && rq.size() == 0) break;
            if (n == max_cyc) begin
                checks++;
                failures++;
                $display("FAIL run_timeout: %0d writes and %0d reads pending after %0d cycles, required 0",
                         wq.size(), rq.size(), n);
                wq.delete();
                rq.delete();
                break;
            end
            drive(p);
            n++;
        end
        idle();
        repeat (LAT + 3) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag);
        checks++;
        if (bus.oc_write_command_taken !== 1'b0 || bus.oc_read_command_taken !== 1'b0 ||
            bus.oc_trans_bvalid !== 1'b0 || bus.oc_trans_rvalid !== 1'b0 ||
            bus.oc_trans_bid !== '0 || bus.oc_trans_bresp !== '0 || bus.oc_trans_rid !== '0 ||
            bus.oc_trans_rdata !== '0 || bus.oc_trans_rresp !== '0 || bus.oc_trans_ruser !== '0) begin
            failures++;
            $display("FAIL %s: got taken=%b%b bvalid=%b rvalid=%b bid=%h rid=%h rresp=%b ruser=%b, required all 0",
                     tag, bus.oc_write_command_taken, bus.oc_read_command_taken, bus.oc_trans_bvalid,
                     bus.oc_trans_rvalid, bus.oc_trans_bid, bus.oc_trans_rid, bus.oc_trans_rresp, bus.oc_trans_ruser);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] da, db, dc;
        idle();
        bus.oc_write_command_ready_id = '0; bus.oc_write_command_ready_address = '0;
        bus.oc_write_command_ready_length = '0; bus.oc_write_command_ready_size = 3'd6;
        bus.oc_write_command_ready_data = '0; bus.oc_write_command_ready_data2 = '0;
        bus.oc_read_command_ready_id = '0; bus.oc_read_command_ready_address = '0;
        bus.oc_read_command_ready_length = '0; bus.oc_read_command_ready_size = 3'd6;

        // Reset state, with both readies asserted to show taken is held off
        bus.oc_write_command_ready = 1'b1;
        bus.oc_read_command_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        idle();
        rst_n = 1'b1;

        // Preload every granule
        for (int i = 0; i < (1 << MAW); i++)
            wq.push_back(mk_cmd(IW'(i), AW'(i * 64), 8'd0, 3'd6, rnd_data(), rnd_data()));
        run(100, 400);

        // Single write then read-back
        da = rnd_data();
        wq.push_back(mk_cmd(12'h005, 64'h40, 8'd0, 3'd6, da, '0));
        run(100, 50);
        rq.push_back(mk_cmd(12'h006, 64'h40, 8'd0, 3'd6, '0, '0));
        run(100, 50);

        // Two-beat write at the top granule wraps into granule 0
        db = rnd_data();
        dc = rnd_data();
        wq.push_back(mk_cmd(12'h010, 64'hFC0, 8'd1, 3'd6, db, dc));
        run(100, 50);
        rq.push_back(mk_cmd(12'h011, 64'hFC0, 8'd1, 3'd6, '0, '0));
        rq.push_back(mk_cmd(12'h012, 64'h000, 8'd0, 3'd6, '0, '0));
        run(100, 50);

        // Simultaneous ready on both channels: round-robin
        for (int i = 0; i < 4; i++) begin
            wq.push_back(rnd_cmd(0));
            rq.push_back(rnd_cmd(0));
        end
        run(100, 100);

        // Error responses; errored write leaves memory untouched
        rq.push_back(mk_cmd(12'h020, 64'h80, 8'd0, 3'd5, '0, '0));
        rq.push_back(mk_cmd(12'h021, 64'h80, 8'd1, 3'd5, '0, '0));
        rq.push_back(mk_cmd(12'h022, 64'h1000, 8'd1, 3'd6, '0, '0));
        run(100, 50);
        wq.push_back(mk_cmd(12'h023, 64'h1000, 8'd0, 3'd6, rnd_data(), '0));
        wq.push_back(mk_cmd(12'h024, 64'h40, 8'd2, 3'd6, rnd_data(), '0));
        wq.push_back(mk_cmd(12'h025, 64'h7, 8'd0, 3'd6, rnd_data(), rnd_data()));
        run(100, 50);
        rq.push_back(mk_cmd(12'h026, 64'h0, 8'd1, 3'd6, '0, '0));
        run(100, 50);

        // Random traffic with gaps, then back-to-back
        for (int i = 0; i < 150; i++) begin
            wq.push_back(rnd_cmd(15));
            rq.push_back(rnd_cmd(15));
        end
        run(60, 4000);
        for (int i = 0; i < 40; i++) begin
            wq.push_back(rnd_cmd(10));
            rq.push_back(rnd_cmd(10));
        end
        run(100, 1000);

        // Reset while the second read beat is due
        rq.push_back(mk_cmd(12'h0AB, 64'h80, 8'd1, 3'd6, '0, '0));
        @(posedge clk);
        #1;
        drive(100);
        @(posedge clk);
        #1;
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("reset_in_beat1");
        wq.push_back(mk_cmd(12'h0CD, 64'h140, 8'd1, 3'd6, rnd_data(), rnd_data()));
        drive(100);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_held");
        rst_n = 1'b1;
        run(100, 50);
        rq.push_back(mk_cmd(12'h0CE, 64'h140, 8'd1, 3'd6, '0, '0));
        run(100, 50);
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ocx_tlx_fbist_oc_responder.md
Name: ocx_tlx_fbist_oc_responder

Overview:
- Far-end responder for the FBIST AXI-to-OpenCAPI transaction bridge.
- Consumes the bridge's OpenCAPI write and read command channels, which use a ready/taken handshake.
- Services commands against an internal 64-byte-granule memory.
- Returns write responses (oc_trans_b*) and read data (oc_trans_r*) after a fixed, parameterised latency.
- Used as a loopback target for FBIST bring-up and for block-level verification of the bridge.

Parameters:
- ADDR_WIDTH, 64, command address width.
- DATA_WIDTH, 512, data beat width (one 64B granule).
- ID_WIDTH, 12, transaction ID width.
- MEM_AW, 6, log2 of internal memory depth in 64B entries (default 64 entries).
- RESP_LATENCY, 2, cycles from the accept cycle to the response-valid cycle; legal range 1..8.

Ports:
- s0_axi_aclk  in  1  clock
- s0_axi_aresetn  in  1  reset; asynchronous assert, active-low
- oc_write_command_ready  in  1  write command (address+data) available
- oc_write_command_ready_id  in  ID_WIDTH  write ID
- oc_write_command_ready_address  in  ADDR_WIDTH  byte address
- oc_write_command_ready_length  in  8  beats minus 1
- oc_write_command_ready_size  in  3  log2 beat bytes
- oc_write_command_ready_data  in  DATA_WIDTH  beat 0 data
- oc_write_command_ready_data2  in  DATA_WIDTH  beat 1 data
- oc_write_command_taken  out  1  one-cycle accept pulse
- oc_read_command_ready  in  1  read command available
- oc_read_command_ready_id  in  ID_WIDTH  read ID
- oc_read_command_ready_address  in  ADDR_WIDTH  byte address
- oc_read_command_ready_length  in  8  beats minus 1
- oc_read_command_ready_size  in  3  log2 beat bytes
- oc_read_command_taken  out  1  one-cycle accept pulse
- oc_trans_bid  out  ID_WIDTH  write response ID
- oc_trans_bresp  out  2  write response code
- oc_trans_bvalid  out  1  write response valid, single cycle
- oc_trans_rid  out  ID_WIDTH  read data ID
- oc_trans_rdata  out  DATA_WIDTH  read beat
- oc_trans_rresp  out  2  read response code
- oc_trans_ruser  out  3  bit0 = last beat; bits 2:1 = 0
- oc_trans_rvalid  out  1  read beat valid, single cycle

Behaviour:
- Reset:
  - All outputs are 0 (taken, bvalid, rvalid, id/resp/data/user).
  - FSM goes to IDLE; arbiter pointer is WRITE-first; response pipelines are flushed.
  - Memory contents are not reset.
- FSM states are IDLE and READ_BEAT1. At most one command is accepted per cycle.
- IDLE arbitration:
  - Only one of write/read ready: accept it.
  - Both ready: round-robin. The pointer flips to the other channel after each accept.
- Accept: drive the matching *_taken high for exactly one cycle, combinational from state and ready. The upstream FIFO pops on that edge.
- Error check at accept, precedence SLVERR > DECERR > OKAY:
  - SLVERR (2'b10): size != 3'd6, or length > 1.
  - DECERR (2'b11): address[ADDR_WIDTH-1 : 6+MEM_AW] != 0.
  - OKAY (2'b00): otherwise. Address bits [5:0] are ignored.
- Index: idx = address[5+MEM_AW : 6]. For the second beat, idx+1 wraps modulo 2^MEM_AW.
- Write accept, OKAY:
  - mem[idx] <= data at the accept edge.
  - If length == 1, mem[idx+1] <= data2 on the same edge.
  - On error, memory is unchanged.
  - One bvalid pulse with the command id/resp occurs exactly RESP_LATENCY cycles after the accept cycle.
- Read accept, OKAY, length 0:
  - Beat 0 = mem[idx], ruser = 3'b001.
  - FSM stays in IDLE.
- Read accept, OKAY, length 1:
  - Beat 0 = mem[idx], ruser = 3'b000.
  - FSM goes to READ_BEAT1.
  - Next cycle: beat 1 = mem[idx+1], ruser = 3'b001, return to IDLE.
  - No command is accepted in READ_BEAT1.
  - The two rvalid beats are on consecutive cycles, each RESP_LATENCY after its issue cycle.
- Read error: a single beat with rdata = 0, rresp = error code, ruser = 3'b001, regardless of length.
- Memory read is combinational at the issue cycle. A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- B and R pipelines are independent shift registers. bvalid and rvalid may assert in the same cycle.
- There is no response backpressure; responses are never dropped.
- Reset mid-operation, including in READ_BEAT1: pending pipeline entries are discarded, no further b/r valids occur, and the FSM returns to IDLE.

Test Plan:
- Write id=0x005, addr=0x40, len=0, size=6, data=A -> one taken pulse; bvalid exactly 2 cycles later with bid=0x005, bresp=00. Then read the same address -> rvalid with rdata=A, rresp=00, ruser=001.
- Write len=1 at addr=0xFC0 (idx 63) with data=B, data2=C; then read len=1 at addr=0xFC0 -> beats B (ruser 000) then C (ruser 001) on consecutive cycles; mem[0]=C, confirming the wrap.
- Write and read ready held simultaneously for 4 commands each -> taken alternates W,R,W,R,...; bvalid and rvalid overlap without loss; all IDs returned in order per channel.
- Read size=5 -> single beat rresp=10, rdata=0. Write addr=0x1000 (out of range) -> bresp=11, and a read of idx 0 is unchanged.
- Deassert s0_axi_aresetn in READ_BEAT1 with a response pending -> all outputs 0 immediately; after release, no stray bvalid/rvalid; the next command completes normally.
- RESP_LATENCY=1 and =8 builds -> the response-to-accept distance matches exactly under back-to-back traffic.
